vmem_arbiter: RTL and testbench
===============================

// Module: vmem_arbiter
// PURPOSE
//  Shares one single-port, synchronous-read data memory between the ARM core's load/store path (CPU) and the video fetch path (VID).
//  The video fetch path is the draw_symbol address/data pair.
//  Sits between SingleCycleARM/draw_symbol and the memory array on the 25 MHz video clock.
//  Replaces the dual-port read path so the memory can map to a single-port block RAM.
// PARAMETERS
//  ADDR_W       32  word address width, both requesters and memory
//  DATA_W       32  data width
//  VID_BURST_MAX 4  consecutive VID grants allowed while CPU waits, before CPU is forced in
// PORTS
//  CLK        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU access request, held with cpu_we/addr/wdata until cpu_gnt
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_gnt    out  1       CPU request accepted this cycle (combinational)
//  cpu_rvalid out  1       cpu_rdata valid this cycle
//  cpu_rdata  out  DATA_W  CPU read data
//  vid_req    in   1       video read request, held with vid_addr until vid_gnt
//  vid_addr   in   ADDR_W  video read address
//  vid_blank  in   1       1 = VGA in blanking; CPU is preferred
//  vid_gnt    out  1       video request accepted this cycle (combinational)
//  vid_rvalid out  1       vid_rdata valid this cycle
//  vid_rdata  out  DATA_W  video read data
//  mem_en     out  1       memory access strobe (registered)
//  mem_we     out  1       memory write enable (registered)
//  mem_addr   out  ADDR_W  memory address (registered)
//  mem_wdata  out  DATA_W  memory write data (registered)
//  mem_rdata  in   DATA_W  memory read data, valid one cycle after mem_en read
// BEHAVIOUR
//  - Reset (reset=0, async): all registered outputs, tag pipe, burst counter and state = 0.
//    Outputs at reset: gnts 0, rvalids 0, mem_* 0, state VID_PRI. rdata outputs are don't-care while their rvalid is 0.
//  - At most one grant per cycle. Exactly one grant whenever any req=1.
//  - Cycle N grant -> mem_en/we/addr/wdata driven in N+1.
//    For reads, <owner>_rvalid=1 and <owner>_rdata=mem_rdata in N+2.
//  - Read latency is 2 cycles from grant; back-to-back grants give one rvalid per cycle, in grant order.
//  - Writes produce no rvalid. Video never writes.
//  - A 2-deep owner-tag pipe (valid, owner, is_read) steers rdata.
//    cpu_rdata and vid_rdata both carry mem_rdata; only the rvalids differ.
//  - FSM, evaluated when cpu_req & vid_req (conflict):
//     VID_PRI: VID wins, unless vid_blank=1, in which case CPU wins.
//     CPU_PRI: CPU wins, then next state = VID_PRI.
//     VID_PRI -> CPU_PRI when burst_cnt reaches VID_BURST_MAX.
//  - With no conflict, the lone requester wins and the state is unchanged (CPU_PRI is held until the CPU is served).
//  - burst_cnt ($clog2(VID_BURST_MAX+1) bits, saturating):
//     +1 on a VID grant while cpu_req=1.
//     Cleared on any CPU grant, or any cycle with cpu_req=0.
//  - Reset asserted mid-transfer: in-flight tags are dropped and no rvalid is emitted after release.
//    Requesters must re-issue.
//  - mem_en=0 in cycles following a no-grant cycle; mem_addr/mem_wdata then hold their last value.
// TESTING
//  - Reset, then CPU read addr 0x10 (mem holds 0xCAFE0001): cpu_gnt in cycle 0, mem_en/mem_addr=0x10 in cycle 1, cpu_rvalid=1 and rdata=0xCAFE0001 in cycle 2.
//  - CPU write 0x20<-0x12345678, then VID read 0x20 next cycle: mem_we=1 in cycle 1, vid_rvalid with 0x12345678 in cycle 3.
//  - cpu_req and vid_req held high, vid_blank=0, VID_BURST_MAX=4: grant pattern V,V,V,V,C,V,V,V,V,C,...
//  - Same as above with vid_blank=1: CPU granted every cycle, vid_gnt=0.
//  - Alternating CPU and VID reads back-to-back: rvalids alternate, each aligned 2 cycles after its own grant, never both high.
//  - Assert reset between a grant and its rvalid: no rvalid after release, mem_en=0, FSM returns to VID_PRI.

Source files
------------

// File: rtl/vmem_arbiter.sv
// Arbitrates one single-port, synchronous-read data memory between the CPU load/store path
// and the video fetch path; read data is steered back to the owner by a 2-deep tag pipe.
module vmem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int VID_BURST_MAX = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_blank,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    // state   | meaning
    // VID_PRI | video wins conflicts unless blanking
    // CPU_PRI | CPU wins next conflict after a full video burst
    typedef enum logic {VID_PRI = 1'b0, CPU_PRI = 1'b1} state_t;

    localparam int CNT_W = $clog2(VID_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VID_BURST_MAX);

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic             tag1_valid, tag1_cpu, tag1_read;
    logic             tag2_valid, tag2_cpu, tag2_read;

    assign cpu_gnt = cpu_req && ((state == CPU_PRI) || vid_blank || !vid_req);
    assign vid_gnt = vid_req && !cpu_gnt;

    // burst_cnt only counts video grants taken while the CPU is kept waiting
    always_comb begin
        burst_nxt = burst_cnt;
        if (cpu_gnt || !cpu_req) begin
            burst_nxt = '0;
        end else if (vid_gnt && (burst_cnt != CNT_MAX)) begin
            burst_nxt = burst_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= VID_PRI;
            burst_cnt  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tag1_valid <= 1'b0;
            tag1_cpu   <= 1'b0;
            tag1_read  <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_cpu   <= 1'b0;
            tag2_read  <= 1'b0;
        end else begin
            burst_cnt <= burst_nxt;
            if (cpu_gnt) begin
                state <= VID_PRI;
            end else if (burst_nxt == CNT_MAX) begin
                state <= CPU_PRI;
            end

            mem_en <= cpu_gnt || vid_gnt;
            mem_we <= cpu_gnt && cpu_we;
            if (cpu_gnt) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (vid_gnt) begin
                mem_addr  <= vid_addr;
            end

            tag1_valid <= cpu_gnt || vid_gnt;
            tag1_cpu   <= cpu_gnt;
            tag1_read  <= vid_gnt || !cpu_we;
            tag2_valid <= tag1_valid;
            tag2_cpu   <= tag1_cpu;
            tag2_read  <= tag1_read;
        end
    end

    assign cpu_rvalid = tag2_valid && tag2_read && tag2_cpu;
    assign vid_rvalid = tag2_valid && tag2_read && !tag2_cpu;
    assign cpu_rdata  = mem_rdata;
    assign vid_rdata  = mem_rdata;
endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: grant table, directed latency/reset sequences and randomized
// protocol-abiding traffic, all checked against a transaction-level reference model.
module tb_vmem_arbiter;
    localparam int BMAX = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        vid_req = 1'b0, vid_blank = 1'b0;
    logic [31:0] vid_addr = '0;
    logic        vid_gnt, vid_rvalid;
    logic [31:0] vid_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    vmem_arbiter #(.ADDR_W(32), .DATA_W(32), .VID_BURST_MAX(BMAX)) dut (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_blank(vid_blank),
        .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(int i);
        return (i == 16) ? 32'hCAFE0001 : (32'h5A5A0000 ^ 32'(i));
    endfunction

    logic [31:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: granted accesses as transactions in a 2-slot latency line
    typedef struct {
        bit          v;
        bit          cpu;
        bit          rd;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
    } op_t;

    op_t         p1, p2;
    int          streak = 0;
    logic [31:0] shadow [0:255];
    initial for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

    logic        o_cg, o_vg, o_crv, o_vrv, o_en, o_we;
    logic [31:0] o_crd, o_vrd, o_addr;

    task automatic step(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                        input bit vr, input logic [31:0] va, input bit vb);
        bit  ecg, evg;
        op_t g;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        vid_req = vr; vid_addr = va; vid_blank = vb;
        @(negedge CLK);
        ecg = cr && (!vr || vb || streak >= BMAX);
        evg = vr && !ecg;
        o_cg = cpu_gnt; o_vg = vid_gnt; o_crv = cpu_rvalid; o_vrv = vid_rvalid;
        o_crd = cpu_rdata; o_vrd = vid_rdata; o_en = mem_en; o_we = mem_we; o_addr = mem_addr;
        chk1("cpu_gnt", cpu_gnt, ecg);
        chk1("vid_gnt", vid_gnt, evg);
        chk1("mem_en", mem_en, p1.v);
        if (p1.v) begin
            chk1("mem_we", mem_we, p1.we);
            chk("mem_addr", mem_addr, p1.addr);
            if (p1.we) chk("mem_wdata", mem_wdata, p1.wdata);
        end
        chk1("cpu_rvalid", cpu_rvalid, p2.v && p2.rd && p2.cpu);
        chk1("vid_rvalid", vid_rvalid, p2.v && p2.rd && !p2.cpu);
        chk1("rvalid_excl", cpu_rvalid && vid_rvalid, 1'b0);
        if (p2.v && p2.rd) begin
            if (p2.cpu) chk("cpu_rdata", cpu_rdata, p2.data);
            else        chk("vid_rdata", vid_rdata, p2.data);
        end
        g.v     = ecg || evg;
        g.cpu   = ecg;
        g.rd    = evg || (ecg && !cw);
        g.we    = ecg && cw;
        g.addr  = ecg ? ca : va;
        g.wdata = cd;
        g.data  = shadow[g.addr[7:0]];
        if (g.we) shadow[g.addr[7:0]] = cd;
        if (ecg || !cr) streak = 0;
        else if (evg)   streak++;
        p2 = p1;
        p1 = g;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        cpu_req = 1'b0; cpu_we = 1'b0; vid_req = 1'b0; vid_blank = 1'b0;
        reset = 1'b0;
        #3;
        chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk1("rst_vid_gnt", vid_gnt, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk1("rst_vid_rvalid", vid_rvalid, 1'b0);
        @(posedge CLK);
        #2 reset = 1'b1;
        streak = 0;
        p1.v = 1'b0;
        p2.v = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    typedef struct { bit cr; bit vr; bit vb; bit ecg; bit evg; } vec_t;
    vec_t tbl [17];

    initial begin
        bit          cp, vp, vb;
        logic        cw;
        logic [31:0] ca, cd, va;

        for (int i = 0; i < 4; i++)  tbl[i] = '{1, 1, 0, 0, 1};
        tbl[4] = '{1, 1, 0, 1, 0};
        for (int i = 5; i < 9; i++)  tbl[i] = '{1, 1, 0, 0, 1};
        tbl[9] = '{1, 1, 0, 1, 0};
        for (int i = 10; i < 13; i++) tbl[i] = '{1, 1, 1, 1, 0};
        tbl[13] = '{1, 0, 0, 1, 0};
        tbl[14] = '{0, 1, 0, 0, 1};
        tbl[15] = '{0, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 0, 0, 1};

        p1.v = 1'b0;
        p2.v = 1'b0;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].cr, 1'b0, 32'h30 + 32'(i), 32'h0, tbl[i].vr, 32'h40 + 32'(i), tbl[i].vb);
            chk1("tbl_cpu_gnt", o_cg, tbl[i].ecg);
            chk1("tbl_vid_gnt", o_vg, tbl[i].evg);
        end
        idle(); idle();

        do_reset();
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
        chk1("rd_gnt_c0", o_cg, 1'b1);
        idle();
        chk1("rd_en_c1", o_en, 1'b1);
        chk("rd_addr_c1", o_addr, 32'h10);
        idle();
        chk1("rd_rvalid_c2", o_crv, 1'b1);
        chk("rd_data_c2", o_crd, 32'hCAFE0001);

        step(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b0);
        chk1("wr_we_c1", o_we, 1'b1);
        idle();
        idle();
        chk1("wv_rvalid_c3", o_vrv, 1'b1);
        chk("wv_data_c3", o_vrd, 32'h12345678);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b0, 32'(i), 32'h0, 1'b0, 32'h0, 1'b0);
            else            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'(i), 1'b0);
            if (i >= 2) chk1("alt_cpu_rvalid", o_crv, (i % 2) == 0);
        end
        idle(); idle();

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 32'h60 + 32'(i), 1'b0);
        do_reset();
        step(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 32'h70, 1'b0);
        chk1("post_rst_vid_pri", o_vg, 1'b1);
        chk1("post_rst_no_crv", o_crv, 1'b0);
        chk1("post_rst_no_vrv", o_vrv, 1'b0);

        do_reset();
        cp = 1'b0; vp = 1'b0; vb = 1'b0;
        cw = 1'b0; ca = '0; cd = '0; va = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!cp && $urandom_range(0, 99) < 60) begin
                cp = 1'b1;
                cw = 1'($urandom_range(0, 1));
                ca = 32'($urandom_range(0, 15));
                cd = $urandom;
            end
            if (!vp && $urandom_range(0, 99) < 70) begin
                vp = 1'b1;
                va = 32'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 19) == 0) vb = !vb;
            step(cp, cw, ca, cd, vp, va, vb);
            if (o_cg) cp = 1'b0;
            if (o_vg) vp = 1'b0;
        end
        idle(); idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
